// File: rtl/div_repeated_sub.sv
// div_repeated_sub: unsigned divider by repeated subtraction (start/busy/done handshake, div_by_zero flag)
module div_repeated_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] SUB   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]       state;
  logic [WIDTH-1:0] a, b, q;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      q           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a     <= dividend;
          b     <= divisor;
          q     <= '0;
          state <= CHECK;
        end
        CHECK: if (b == '0) begin
          quotient    <= '1;
          remainder   <= a;
          div_by_zero <= 1'b1;
          state       <= DONE;
        end else state <= SUB;
        SUB: if (a >= b) begin
          a <= a - b;
          q <= q + 1'b1;
        end else begin
          quotient    <= q;
          remainder   <= a;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
